// File: rtl/shift_register_pkg.sv
// Shared definitions for the shift_register block: operation-select encodings.
package shift_register_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_register.sv
// Bidirectional shift register with serial in/out and parallel load/readout.
// Serialises/deserialises ULPI bytes in the sniffer datapath.
// Optional build macro SHIFT_REGISTER_DONE_EN adds a saturating shift counter
// (shift_cnt) and a one-cycle done pulse when BITS shifts follow a load.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bit_in,
  output logic            bit_out,
  input  logic [BITS-1:0] DATA_IN,
  output logic [BITS-1:0] DATA,
  input  logic [1:0]      mode
`ifdef SHIFT_REGISTER_DONE_EN
  ,
  output logic [$clog2(BITS+1)-1:0] shift_cnt,
  output logic                      done
`endif
);

  logic [BITS-1:0] data_d, data_q;
  logic            bit_d, bit_q;

  // Next-state decode of the selected operation.
  always_comb begin
    data_d = data_q;
    bit_d  = bit_q;
    case (mode)
      MODE_SHR: begin
        data_d = {bit_in, data_q[BITS-1:1]};
        bit_d  = data_q[0];
      end
      MODE_SHL: begin
        data_d = {data_q[BITS-2:0], bit_in};
        bit_d  = data_q[BITS-1];
      end
      MODE_LOAD: data_d = DATA_IN;
      default: ;
    endcase
  end

  // Data and serial-out state; cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      bit_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      bit_q  <= bit_d;
    end
  end

  assign DATA    = data_q;
  assign bit_out = bit_q;

`ifdef SHIFT_REGISTER_DONE_EN
  localparam int unsigned CntW = $clog2(BITS + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(BITS - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            done_d, done_q;
  logic            shifting;

  // Count shifts since the last load; done fires only on the step that reaches BITS.
  always_comb begin
    shifting = (mode == MODE_SHR) || (mode == MODE_SHL);
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (mode == MODE_LOAD) begin
      cnt_d = '0;
    end else if (shifting && (cnt_q != CntMax)) begin
      cnt_d  = cnt_q + 1'b1;
      done_d = (cnt_q == CntLast);
    end
  end

  // Counter and done-pulse state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign shift_cnt = cnt_q;
  assign done      = done_q;
`endif

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register (BITS=8): table-driven vectors plus
// hand-written reset and mid-cycle sequences.
module tb_shift_register;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_out;
  logic [7:0] data_in;
  logic [7:0] data;
  logic [1:0] mode;
`ifdef SHIFT_REGISTER_DONE_EN
  logic [3:0] shift_cnt;
  logic       done;
`endif

  shift_register #(.BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_out  (bit_out),
    .DATA_IN  (data_in),
    .DATA     (data),
    .mode     (mode)
`ifdef SHIFT_REGISTER_DONE_EN
    ,
    .shift_cnt(shift_cnt),
    .done     (done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       bi;
    logic [7:0] din;
    logic [7:0] exp_data;
    logic       exp_bo;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic [1:0] m, logic b, logic [7:0] d, logic [7:0] ed, logic eb);
    vec_t v;
    v.mode = m; v.bi = b; v.din = d; v.exp_data = ed; v.exp_bo = eb;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Shift left from zero.
    add(LOAD, 0, 8'h00, 8'h00, 0);
    add(SHL, 1, 8'h00, 8'h01, 0);
    add(SHL, 1, 8'h00, 8'h03, 0);
    add(SHL, 1, 8'h00, 8'h07, 0);
    add(SHL, 1, 8'h00, 8'h0F, 0);
    add(SHL, 0, 8'h00, 8'h1E, 0);
    add(SHL, 0, 8'h00, 8'h3C, 0);
    add(SHL, 1, 8'h00, 8'h79, 0);
    add(SHL, 1, 8'h00, 8'hF3, 0);
    add(SHL, 1, 8'h00, 8'hE7, 1);
    add(SHL, 1, 8'h00, 8'hCF, 1);
    // Load keeps bit_out; shift right with zeros in.
    add(LOAD, 0, 8'hFA, 8'hFA, 1);
    add(SHR, 0, 8'h00, 8'h7D, 0);
    add(SHR, 0, 8'h00, 8'h3E, 1);
    add(SHR, 0, 8'h00, 8'h1F, 0);
    add(SHR, 0, 8'h00, 8'h0F, 1);
    add(SHR, 0, 8'h00, 8'h07, 1);
    add(SHR, 0, 8'h00, 8'h03, 1);
    add(SHR, 0, 8'h00, 8'h01, 1);
    add(SHR, 0, 8'h00, 8'h00, 1);
    for (int i = 0; i < 4; i++) add(SHR, 0, 8'h00, 8'h00, 0);
    // Hold with noisy bit_in/DATA_IN.
    add(LOAD, 0, 8'hFA, 8'hFA, 0);
    for (int i = 0; i < 12; i++) add(HOLD, i[0], 8'h5A, 8'hFA, 0);
    // Shift right, ones in.
    add(LOAD, 1, 8'hFA, 8'hFA, 0);
    add(SHR, 1, 8'h00, 8'hFD, 0);
    add(SHR, 1, 8'h00, 8'hFE, 1);
    add(SHR, 1, 8'h00, 8'hFF, 0);
    for (int i = 0; i < 5; i++) add(SHR, 1, 8'h00, 8'hFF, 1);
    // Shift left, ones in.
    add(LOAD, 1, 8'hFA, 8'hFA, 1);
    add(SHL, 1, 8'h00, 8'hF5, 1);
    add(SHL, 1, 8'h00, 8'hEB, 1);
    add(SHL, 1, 8'h00, 8'hD7, 1);
    add(SHL, 1, 8'h00, 8'hAF, 1);
    add(SHL, 1, 8'h00, 8'h5F, 1);
    add(SHL, 1, 8'h00, 8'hBF, 0);
    add(SHL, 1, 8'h00, 8'h7F, 1);
    add(SHL, 1, 8'h00, 8'hFF, 0);
    // Leave a non-zero state with bit_out=1 ahead of the reset test.
    add(SHR, 0, 8'h00, 8'h7F, 1);

    // Power-on reset.
    rst = 1'b0; mode = LOAD; data_in = 8'hFA; bit_in = 1'b1;
    #3;
    check("por_data", {24'd0, data}, 32'h00);
    check("por_bit_out", {31'd0, bit_out}, 32'h0);
    @(negedge clk);
    check("por_data_after_edge", {24'd0, data}, 32'h00);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      mode = vecs[i].mode; bit_in = vecs[i].bi; data_in = vecs[i].din;
      @(posedge clk); #1;
      check($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_bit_out", i), {31'd0, bit_out}, {31'd0, vecs[i].exp_bo});
    end

    // Asynchronous reset mid-cycle with a pending load.
    @(negedge clk);
    mode = LOAD; data_in = 8'hFA;
    #2 rst = 1'b0;
    #1;
    check("async_rst_data", {24'd0, data}, 32'h00);
    check("async_rst_bit_out", {31'd0, bit_out}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_held_data", {24'd0, data}, 32'h00);
      check("rst_held_bit_out", {31'd0, bit_out}, 32'h0);
    end
    // Release mid-cycle: nothing happens until the next rising edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_release_no_op", {24'd0, data}, 32'h00);
    @(posedge clk); #1;
    check("rst_release_load", {24'd0, data}, 32'hFA);
    check("rst_release_bit_out", {31'd0, bit_out}, 32'h0);

    // Mid-cycle input changes: only the value present at the edge counts.
    @(negedge clk);
    mode = LOAD; data_in = 8'h55;
    #2 data_in = 8'h33;
    #1;
    check("midcycle_no_effect", {24'd0, data}, 32'hFA);
    @(posedge clk); #1;
    check("midcycle_load_last", {24'd0, data}, 32'h33);
    mode = HOLD;
    @(posedge clk); #1;
    check("midcycle_hold", {24'd0, data}, 32'h33);

`ifdef SHIFT_REGISTER_DONE_EN
    // Counter and done pulse across 10 shifts after a load.
    @(negedge clk);
    mode = LOAD; data_in = 8'h00;
    @(posedge clk); #1;
    check("cnt_after_load", {28'd0, shift_cnt}, 32'd0);
    check("done_after_load", {31'd0, done}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mode = (i < 5) ? SHL : SHR; bit_in = 1'b1;
      @(posedge clk); #1;
      check($sformatf("cnt_shift%0d", i + 1), {28'd0, shift_cnt},
            (i + 1 > 8) ? 32'd8 : 32'(i + 1));
      check($sformatf("done_shift%0d", i + 1), {31'd0, done}, (i == 7) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    mode = LOAD;
    @(posedge clk); #1;
    check("cnt_reload", {28'd0, shift_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
